flexbex_ibex_data_arbiter: RTL and testbench
============================================

Name: flexbex_ibex_data_arbiter

Overview:
- Shares the single core data-memory port (req/gnt/rvalid, in-order responses) between two requesters: m0 = core load/store unit, m1 = accelerator/eFPGA data master.
- Sits between both masters and the data bus.
- Arbitrates requests and holds the selected request stable until granted.
- Tracks outstanding transactions in an ID FIFO so each rvalid/err goes back to its owner.

Parameters:
- MAX_OUTSTANDING, 2, depth of the outstanding-ID FIFO (1..4); new grants are blocked while it is full.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m0_req_i / m1_req_i  in  1  request from master 0 / 1
- m0_addr_i / m1_addr_i  in  32  byte address
- m0_we_i / m1_we_i  in  1  write enable
- m0_be_i / m1_be_i  in  4  byte enables
- m0_wdata_i / m1_wdata_i  in  32  write data
- m0_gnt_o / m1_gnt_o  out  1  grant to master 0 / 1
- m0_rvalid_o / m1_rvalid_o  out  1  response valid to owner
- m0_err_o / m1_err_o  out  1  response error to owner
- m0_rdata_o / m1_rdata_o  out  32  read data (data_rdata_i broadcast)
- data_req_o  out  1  bus request
- data_gnt_i  in  1  bus grant
- data_rvalid_i  in  1  bus response valid
- data_err_i  in  1  bus response error
- data_addr_o  out  32  muxed address
- data_we_o  out  1  muxed write enable
- data_be_o  out  4  muxed byte enables
- data_wdata_o  out  32  muxed write data
- data_rdata_i  in  32  bus read data
- busy_o  out  1  high when the FIFO is non-empty or a request is locked

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - state IDLE, FIFO empty, priority pointer = m0.
  - All outputs low; data_addr_o/data_wdata_o/data_be_o = 0.
- States:
  - IDLE: no pending bus request.
  - LOCKED: request presented, not yet granted; owner_q holds the selected master.
- Grants are blocked while the FIFO holds MAX_OUTSTANDING entries; no grant is issued in that cycle even if a pop happens in the same cycle.
- IDLE transitions (FIFO not full):
  - Select a winner among the asserted requests; data_req_o=1, mux the winner's fields combinationally.
  - data_gnt_i=1: assert winner gnt the same cycle (zero-latency pass-through), push winner ID, stay IDLE, update the priority pointer.
  - data_gnt_i=0: owner_q <= winner, go LOCKED.
- LOCKED:
  - data_req_o=1 with owner_q's fields regardless of the other master; the owner must keep its req stable.
  - On data_gnt_i: owner gnt=1, push owner_q, update the pointer, go IDLE.
  - If the owner drops req (protocol violation): return to IDLE without a grant.
- Arbitration (default): round-robin.
  - When both request, the master not granted last wins; pointer = the other master after every grant.
  - A single requester always wins.
- Responses:
  - data_rvalid_i pops the FIFO head; mX_rvalid_o = data_rvalid_i & head==X; mX_err_o = data_err_i & head==X.
  - Push and pop in the same cycle are both performed, count unchanged.
  - rvalid with an empty FIFO is dropped: no master rvalid, no state change; simulation assertion fires.
- Write data/byte enables pass through unmodified; no address translation.
- Reset mid-transaction clears the FIFO and lock; responses still in flight afterwards are dropped as above.

Optional Feature:
- Macro: FLEXBEX_DATA_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, m0 (LSU) always wins a tie; the priority pointer is not implemented.
- Undefined: round-robin as above.
- LOCKED stickiness applies in both modes.

Decomposition:
- Package flexbex_ibex_data_arb_pkg:
  - master-ID typedef (1 bit: MST_LSU=0, MST_ACC=1)
  - state enum {ARB_IDLE, ARB_LOCKED}
  - MAX_OUTSTANDING limit constant
- Sub-module flexbex_ibex_data_arb_idfifo: synchronous FIFO of master IDs with push/pop/full/empty/head, depth parameter, async active-low reset.

Test Plan:
- m0 only, addr 0x1000, gnt same cycle, rvalid next cycle rdata 0xDEADBEEF -> m0_gnt_o same cycle; m0_rvalid_o=1 with m0_rdata_o=0xDEADBEEF; m1_rvalid_o=0.
- Both request every cycle, gnt always 1 (round-robin) -> grants alternate m0,m1,m0,m1; with FLEXBEX_DATA_ARB_FIXED_PRIO_EN, m0 every cycle.
- m1 selected, gnt held low 3 cycles while m0 requests addr 0x2000 -> data_addr_o stays at m1's 0x3000 for all 3 cycles; m1 granted first, m0 next.
- MAX_OUTSTANDING=2: two grants, no rvalid -> third req gets no gnt; data_rvalid_i pops one entry -> grant resumes the following cycle.
- Interleaved m0 then m1 grants; responses with err=1 then err=0 -> m0_err_o=1 on first rvalid, m1_rvalid_o=1 with err=0 on second.
- rst_n pulsed low with 2 outstanding, then a stray rvalid -> no master rvalid, busy_o=0, assertion flagged.

Source files
------------

// File: rtl/flexbex_ibex_data_arb_pkg.sv
// flexbex_ibex_data_arb_pkg: master IDs, arbiter states and outstanding-depth limits
// shared by the data-port arbiter and its ID FIFO.
package flexbex_ibex_data_arb_pkg;
    typedef enum logic {MST_LSU = 1'b0, MST_ACC = 1'b1} mst_id_e;
    typedef enum logic {ARB_IDLE = 1'b0, ARB_LOCKED = 1'b1} arb_state_e;
    localparam int unsigned MAX_OUTSTANDING_DEF = 2;
    localparam int unsigned MAX_OUTSTANDING_LIMIT = 4;
endpackage

// File: rtl/flexbex_ibex_data_arb_idfifo.sv
// flexbex_ibex_data_arb_idfifo: in-order FIFO of master IDs for granted, unanswered bus
// transactions; push when full and pop when empty are ignored.
module flexbex_ibex_data_arb_idfifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem_q;
    logic [PW-1:0]    rd_q, wr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = cnt_q == CW'(DEPTH);
    assign empty   = cnt_q == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_id;
                wr_q        <= nxt(wr_q);
            end
            if (do_pop) rd_q <= nxt(rd_q);
            if (do_push != do_pop) cnt_q <= do_push ? cnt_q + CW'(1) : cnt_q - CW'(1);
        end
    end
endmodule

// File: rtl/flexbex_ibex_data_arbiter.sv
// flexbex_ibex_data_arbiter: shares the core data port between the LSU (m0) and the accelerator (m1).
// Round-robin by default; define FLEXBEX_DATA_ARB_FIXED_PRIO_EN for fixed m0 priority.
module flexbex_ibex_data_arbiter
    import flexbex_ibex_data_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_wdata_i,
    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m0_gnt_o,
    output logic        m1_gnt_o,
    output logic        m0_rvalid_o,
    output logic        m1_rvalid_o,
    output logic        m0_err_o,
    output logic        m1_err_o,
    output logic [31:0] m0_rdata_o,
    output logic [31:0] m1_rdata_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    output logic        busy_o
);
    arb_state_e state_q, state_d;
    mst_id_e    owner_q, owner_d, winner, sel;
    logic       sel_req, gnt, fifo_full, fifo_empty, fifo_head, rsp_ok, stray_rvalid;

`ifdef FLEXBEX_DATA_ARB_FIXED_PRIO_EN
    assign winner = m0_req_i ? MST_LSU : MST_ACC;
`else
    mst_id_e prio_q;
    assign winner = (m0_req_i & m1_req_i) ? prio_q : (m1_req_i ? MST_ACC : MST_LSU);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prio_q <= MST_LSU;
        else if (gnt) prio_q <= (sel == MST_LSU) ? MST_ACC : MST_LSU;
    end
`endif

    // once locked, the bus sees the owner's request regardless of the other master
    assign sel          = (state_q == ARB_LOCKED) ? owner_q : winner;
    assign sel_req      = (sel == MST_ACC) ? m1_req_i : m0_req_i;
    assign data_req_o   = sel_req & ~fifo_full;
    assign gnt          = data_req_o & data_gnt_i;
    assign m0_gnt_o     = gnt & (sel == MST_LSU);
    assign m1_gnt_o     = gnt & (sel == MST_ACC);
    assign data_addr_o  = !data_req_o ? '0 : (sel == MST_ACC) ? m1_addr_i : m0_addr_i;
    assign data_we_o    = data_req_o & ((sel == MST_ACC) ? m1_we_i : m0_we_i);
    assign data_be_o    = !data_req_o ? '0 : (sel == MST_ACC) ? m1_be_i : m0_be_i;
    assign data_wdata_o = !data_req_o ? '0 : (sel == MST_ACC) ? m1_wdata_i : m0_wdata_i;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        if (state_q == ARB_IDLE) begin
            if (data_req_o && !data_gnt_i) begin
                state_d = ARB_LOCKED;
                owner_d = winner;
            end
        end else if (!sel_req || data_gnt_i) begin
            state_d = ARB_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            owner_q <= MST_LSU;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    flexbex_ibex_data_arb_idfifo #(.DEPTH(MAX_OUTSTANDING)) u_idfifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (gnt),
        .push_id (sel == MST_ACC),
        .pop     (data_rvalid_i),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    assign rsp_ok       = data_rvalid_i & ~fifo_empty;
    assign stray_rvalid = data_rvalid_i & fifo_empty;
    assign m0_rvalid_o  = rsp_ok & ~fifo_head;
    assign m1_rvalid_o  = rsp_ok & fifo_head;
    assign m0_err_o     = rsp_ok & data_err_i & ~fifo_head;
    assign m1_err_o     = rsp_ok & data_err_i & fifo_head;
    assign m0_rdata_o   = data_rdata_i;
    assign m1_rdata_o   = data_rdata_i;
    assign busy_o       = ~fifo_empty | (state_q == ARB_LOCKED);

    assert property (@(posedge clk) disable iff (!rst_n) !stray_rvalid)
        else $warning("data arbiter: rvalid with no outstanding transaction dropped");
endmodule

// File: tb/tb_flexbex_ibex_data_arbiter.sv
// tb_flexbex_ibex_data_arbiter: directed and random checks of the data-port arbiter
// against a queue-based reference model.
module tb_flexbex_ibex_data_arbiter;
    localparam int MAXO = 2;

    logic        clk = 0, rst_n = 0;
    logic        m0_req = 0, m1_req = 0, m0_we = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0;
    logic [3:0]  m0_be = 0, m1_be = 0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        data_req, data_gnt = 0, data_rvalid = 0, data_err = 0, data_we, busy;
    logic [31:0] data_addr, data_wdata, data_rdata = 0;
    logic [3:0]  data_be;

    int checks = 0, fails = 0;
    int q[$];
    int lock_own = -1;
    int last_gnt = 1;

    always #5 clk = ~clk;

    flexbex_ibex_data_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_wdata_i(m0_wdata),
        .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_wdata_i(m1_wdata),
        .m0_gnt_o(m0_gnt), .m1_gnt_o(m1_gnt), .m0_rvalid_o(m0_rvalid), .m1_rvalid_o(m1_rvalid),
        .m0_err_o(m0_err), .m1_err_o(m1_err), .m0_rdata_o(m0_rdata), .m1_rdata_o(m1_rdata),
        .data_req_o(data_req), .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid), .data_err_i(data_err),
        .data_addr_o(data_addr), .data_we_o(data_we), .data_be_o(data_be), .data_wdata_o(data_wdata),
        .data_rdata_i(data_rdata), .busy_o(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        if (lock_own >= 0) return lock_own;
`ifdef FLEXBEX_DATA_ARB_FIXED_PRIO_EN
        return m0_req ? 0 : 1;
`else
        if (m0_req && m1_req) return 1 - last_gnt;
        return m1_req ? 1 : 0;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        lock_own = -1;
        last_gnt = 1;
    endtask

    task automatic clear_inputs();
        m0_req = 0; m1_req = 0; data_gnt = 0; data_rvalid = 0; data_err = 0;
    endtask

    // one cycle: inputs already driven at negedge; check outputs, then advance the model
    task automatic step(input string tag);
        int s, h;
        bit rs, ereq;
        #1;
        s    = pick();
        rs   = s ? m1_req : m0_req;
        ereq = rs && q.size() < MAXO;
        h    = (data_rvalid && q.size() > 0) ? q[0] : -1;
        check({tag, ".req"}, data_req, ereq);
        check({tag, ".gnt0"}, m0_gnt, ereq && data_gnt && s == 0);
        check({tag, ".gnt1"}, m1_gnt, ereq && data_gnt && s == 1);
        check({tag, ".addr"}, data_addr, !ereq ? 0 : s ? m1_addr : m0_addr);
        check({tag, ".wdata"}, data_wdata, !ereq ? 0 : s ? m1_wdata : m0_wdata);
        check({tag, ".be"}, data_be, !ereq ? 0 : s ? m1_be : m0_be);
        check({tag, ".we"}, data_we, ereq && (s ? m1_we : m0_we));
        check({tag, ".rv0"}, m0_rvalid, h == 0);
        check({tag, ".rv1"}, m1_rvalid, h == 1);
        check({tag, ".err0"}, m0_err, h == 0 && data_err);
        check({tag, ".err1"}, m1_err, h == 1 && data_err);
        check({tag, ".rdata"}, m1_rdata, data_rdata);
        check({tag, ".busy"}, busy, q.size() > 0 || lock_own >= 0);
        check({tag, ".stray"}, dut.stray_rvalid, data_rvalid && q.size() == 0);
        @(posedge clk);
        if (h >= 0) void'(q.pop_front());
        if (ereq && data_gnt) begin
            q.push_back(s);
            last_gnt = s;
            lock_own = -1;
        end else if (lock_own >= 0) begin
            if (!rs) lock_own = -1;
        end else if (ereq) begin
            lock_own = s;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        clear_inputs();
        for (int i = 0; i < 8 && q.size() > 0; i++) begin
            data_rvalid = 1;
            data_rdata = $urandom;
            step("drain");
        end
        data_rvalid = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst.req", data_req, 0);
        check("rst.busy", busy, 0);
        check("rst.addr", data_addr, 0);
        check("rst.gnt", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 0);
        rst_n = 1;
        @(negedge clk);

        // single LSU read with zero-latency grant and next-cycle response
        m0_req = 1; m0_addr = 32'h1000; m0_be = 4'hf; data_gnt = 1;
        #1;
        check("t1.gnt0", m0_gnt, 1);
        check("t1.addr", data_addr, 32'h1000);
        step("t1a");
        clear_inputs();
        data_rvalid = 1; data_rdata = 32'hDEADBEEF;
        #1;
        check("t1.rv0", m0_rvalid, 1);
        check("t1.rdata", m0_rdata, 32'hDEADBEEF);
        check("t1.rv1", m1_rvalid, 0);
        step("t1b");

        // both masters every cycle, bus always grants
        m1_addr = 32'h0000_4000; m1_be = 4'h3;
        for (int i = 0; i < 4; i++) begin
            m0_req = 1; m1_req = 1; data_gnt = 1;
            data_rvalid = q.size() > 0;
`ifdef FLEXBEX_DATA_ARB_FIXED_PRIO_EN
            #1 check("t2.gnt1", m1_gnt, 0);
`else
            #1 check("t2.gnt1", m1_gnt, (i % 2) == 0);
`endif
            step("t2");
        end
        drain();

        // m1 locks the bus; m0's later request must not disturb it
        m1_req = 1; m1_addr = 32'h3000; m0_addr = 32'h2000;
        for (int i = 0; i < 3; i++) begin
            m0_req = (i > 0);
            #1 check("t3.addr", data_addr, 32'h3000);
            step("t3");
        end
        data_gnt = 1;
        #1 check("t3.gnt1", m1_gnt, 1);
        step("t3g1");
        m1_req = 0;
        #1 check("t3.gnt0", m0_gnt, 1);
        step("t3g0");
        drain();

        // outstanding limit: third request blocked, even in the popping cycle
        m0_req = 1; data_gnt = 1; m0_addr = 32'h5000;
        step("t4a");
        step("t4b");
        #1 check("t4.block", {data_req, m0_gnt}, 0);
        step("t4c");
        data_rvalid = 1;
        #1 check("t4.blockpop", m0_gnt, 0);
        step("t4d");
        data_rvalid = 0;
        #1 check("t4.resume", m0_gnt, 1);
        step("t4e");
        drain();

        // responses routed with error to their owners
        m0_req = 1; data_gnt = 1;
        step("t5a");
        m0_req = 0; m1_req = 1;
        step("t5b");
        clear_inputs();
        data_rvalid = 1; data_err = 1;
        #1 check("t5.err0", {m0_rvalid, m0_err}, 2'b11);
        step("t5c");
        data_err = 0;
        #1 check("t5.rv1", {m1_rvalid, m1_err}, 2'b10);
        step("t5d");
        clear_inputs();

        // random traffic honouring the hold-while-locked rule (with rare drops)
        for (int i = 0; i < 400; i++) begin
            if (lock_own == 0) m0_req = ($urandom_range(0, 31) != 0);
            else begin
                m0_req = $urandom_range(0, 1); m0_addr = $urandom; m0_we = $urandom_range(0, 1);
                m0_be = 4'($urandom); m0_wdata = $urandom;
            end
            if (lock_own == 1) m1_req = ($urandom_range(0, 31) != 0);
            else begin
                m1_req = $urandom_range(0, 1); m1_addr = $urandom; m1_we = $urandom_range(0, 1);
                m1_be = 4'($urandom); m1_wdata = $urandom;
            end
            data_gnt = $urandom_range(0, 1);
            data_rvalid = q.size() > 0 && $urandom_range(0, 2) != 0;
            data_err = data_rvalid && $urandom_range(0, 1);
            data_rdata = $urandom;
            step("rand");
        end
        drain();

        // reset with two outstanding, then a stray response
        m0_req = 1; data_gnt = 1;
        step("t6a");
        m0_req = 0; m1_req = 1;
        step("t6b");
        clear_inputs();
        rst_n = 0;
        model_reset();
        #1 check("t6.busyrst", busy, 0);
        @(negedge clk);
        rst_n = 1;
        data_rvalid = 1;
        #1;
        check("t6.rv", {m0_rvalid, m1_rvalid}, 0);
        check("t6.flag", dut.stray_rvalid, 1);
        step("t6c");
        clear_inputs();
        step("t6d");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
